// File: rtl/local_average_pad_v2.sv
`default_nettype none
// ============================================================================
// Module      : local_average_pad_v2 (with helper local_average_pad_v2_fifo)
// Description : Pairs every pixel of a line with a local-average value. The
//               average stream is shorter than the pixel line by 2*RADIUS,
//               so both line ends are padded with an edge value. The output
//               is one {sof, average, pixel} word per pixel, under
//               valid/ready flow control.
// Revision    : 1.0 - initial parametrised release
// ============================================================================

// Show-ahead FIFO with a synchronous flush. The flush can keep a word that
// is written in the same cycle: that word becomes the only entry.
module local_average_pad_v2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_wr_drop
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_full;
    logic             w_mem_we;
    logic [c_AW-1:0]  w_waddr;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_wr_drop = i_wr_en && w_full && !i_flush;
    assign w_mem_we  = i_wr_en && (i_flush || !w_full);
    assign w_waddr   = i_flush ? '0 : r_wr_ptr[c_AW-1:0];
    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update; a flush restarts both pointers at slot 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= i_wr_en ? {{c_AW{1'b0}}, 1'b1} : '0;
        end else begin
            if (i_wr_en && !w_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; no reset needed since pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_waddr] <= i_wr_data;
        end
    end
endmodule

module local_average_pad_v2 #(
    parameter int PIX_W       = 8,
    parameter int AVG_W       = 8,
    parameter int RADIUS      = 8,
    parameter int FRAME_WIDTH = 768,
    parameter int FRAME_LINES = 480,
    parameter int EDGE_MODE   = 0,
    parameter int EDGE_CONST  = 0,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PIX_W:0]           pixel,
    input  logic                     pixel_valid,
    input  logic [AVG_W-1:0]         local_average,
    input  logic                     local_average_valid,
    input  logic                     out_ready,
    output logic [PIX_W+AVG_W:0]     out_data,
    output logic                     out_valid,
    output logic                     overflow,
    output logic                     sync_error,
    output logic                     frame_done
);
    localparam int c_COL_W  = $clog2(FRAME_WIDTH);
    localparam int c_LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    localparam logic [1:0] c_WAIT_SOF = 2'd0;
    localparam logic [1:0] c_LEAD     = 2'd1;
    localparam logic [1:0] c_MID      = 2'd2;
    localparam logic [1:0] c_TRAIL    = 2'd3;
    // With no radius there are no edge beats, so every line starts in MID.
    localparam logic [1:0] c_START    = (RADIUS == 0) ? c_MID : c_LEAD;

    localparam logic [c_COL_W-1:0]  c_COL_LAST  = c_COL_W'(FRAME_WIDTH - 1);
    localparam logic [c_COL_W-1:0]  c_LEAD_LAST = c_COL_W'((RADIUS > 0) ? RADIUS - 1 : 0);
    localparam logic [c_COL_W-1:0]  c_MID_LAST  = c_COL_W'(FRAME_WIDTH - RADIUS - 1);
    localparam logic [c_LINE_W-1:0] c_LINE_LAST = c_LINE_W'(FRAME_LINES - 1);
    localparam logic [AVG_W-1:0]    c_EDGE      = AVG_W'(EDGE_CONST);

    logic [1:0]              r_state;
    logic [c_COL_W-1:0]      r_col;
    logic [c_LINE_W-1:0]     r_line;
    logic [AVG_W-1:0]        r_last_avg;
    logic [PIX_W+AVG_W:0]    r_out_data;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_overflow;
    logic                    r_sync_error;

    logic [PIX_W:0]          w_pix_head;
    logic [AVG_W-1:0]        w_avg_head;
    logic                    w_pix_empty;
    logic                    w_avg_empty;
    logic                    w_pix_drop;
    logic                    w_avg_drop;
    logic                    w_can_issue;
    logic                    w_pop_avg;
    logic [AVG_W-1:0]        w_beat_avg;
    logic                    w_xfer;
    logic                    w_slot;
    logic                    w_issue_raw;
    logic                    w_issue;
    logic                    w_eol;
    logic                    w_last_line;
    logic                    w_eof;
    logic                    w_sof_in;
    logic                    w_sof_err;
    logic                    w_flush;
    logic                    w_pix_wr;
    logic                    w_avg_wr;

    assign w_xfer      = r_out_valid && out_ready;
    assign w_slot      = !r_out_valid || out_ready;
    assign w_eol       = (r_col == c_COL_LAST);
    assign w_last_line = (r_line == c_LINE_LAST);
    assign w_issue_raw = w_slot && w_can_issue;
    assign w_eof       = w_issue_raw && w_eol && w_last_line;
    assign w_sof_in    = pixel_valid && pixel[PIX_W];
    // An SOF that coincides with the final beat of a frame is a clean start.
    assign w_sof_err   = w_sof_in && (r_state != c_WAIT_SOF) && !w_eof;
    assign w_issue     = w_issue_raw && !w_sof_err;
    assign w_flush     = w_sof_err || w_eof;
    // At end of frame only an incoming SOF pixel survives the flush.
    assign w_pix_wr    = pixel_valid &&
                         (pixel[PIX_W] || ((r_state != c_WAIT_SOF) && !w_eof));
    assign w_avg_wr    = local_average_valid && (r_state != c_WAIT_SOF) &&
                         !w_sof_err && (!w_eof || w_sof_in);

    local_average_pad_v2_fifo #(
        .WIDTH (PIX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_flush   (w_flush),
        .i_wr_en   (w_pix_wr),
        .i_wr_data (pixel),
        .i_rd_en   (w_issue),
        .o_rd_data (w_pix_head),
        .o_empty   (w_pix_empty),
        .o_wr_drop (w_pix_drop)
    );

    local_average_pad_v2_fifo #(
        .WIDTH (AVG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_avg_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_flush   (w_flush),
        .i_wr_en   (w_avg_wr),
        .i_wr_data (local_average),
        .i_rd_en   (w_issue && w_pop_avg),
        .o_rd_data (w_avg_head),
        .o_empty   (w_avg_empty),
        .o_wr_drop (w_avg_drop)
    );

    // Per-state beat readiness and choice of the average paired with the pixel.
    always_comb begin
        w_can_issue = 1'b0;
        w_pop_avg   = 1'b0;
        w_beat_avg  = '0;
        case (r_state)
            c_LEAD: begin
                w_can_issue = !w_pix_empty && ((EDGE_MODE == 1) || !w_avg_empty);
                w_beat_avg  = (EDGE_MODE == 1) ? c_EDGE : w_avg_head;
            end
            c_MID: begin
                w_can_issue = !w_pix_empty && !w_avg_empty;
                w_pop_avg   = 1'b1;
                w_beat_avg  = w_avg_head;
            end
            c_TRAIL: begin
                w_can_issue = !w_pix_empty;
                w_beat_avg  = (EDGE_MODE == 1) ? c_EDGE : r_last_avg;
            end
            default: begin
                w_can_issue = 1'b0;
            end
        endcase
    end

    // Line/frame sequencing: counters advance as each beat is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_WAIT_SOF;
            r_col      <= '0;
            r_line     <= '0;
            r_last_avg <= '0;
        end else begin
            if (w_sof_err || ((r_state == c_WAIT_SOF) && w_sof_in)) begin
                r_state <= c_START;
                r_col   <= '0;
                r_line  <= '0;
            end else if (w_issue) begin
                r_col <= w_eol ? '0 : r_col + 1'b1;
                if (w_eol) begin
                    if (w_last_line) begin
                        r_line  <= '0;
                        r_state <= w_sof_in ? c_START : c_WAIT_SOF;
                    end else begin
                        r_line  <= r_line + 1'b1;
                        r_state <= c_START;
                    end
                end else if ((r_state == c_LEAD) && (r_col == c_LEAD_LAST)) begin
                    r_state <= c_MID;
                end else if ((r_state == c_MID) && (r_col == c_MID_LAST)) begin
                    r_state <= c_TRAIL;
                end
            end
            if (w_issue && w_pop_avg) begin
                r_last_avg <= w_avg_head;
            end
        end
    end

    // Single output register; reloads on the transfer cycle for full rate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_sof_err) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_issue) begin
            r_out_data  <= {w_pix_head[PIX_W], w_beat_avg, w_pix_head[PIX_W-1:0]};
            r_out_valid <= 1'b1;
            r_out_last  <= w_eof;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_sync_error <= 1'b0;
        end else begin
            r_overflow   <= r_overflow | w_pix_drop | w_avg_drop;
            r_sync_error <= r_sync_error | w_sof_err;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign overflow   = r_overflow;
    assign sync_error = r_sync_error;
    assign frame_done = r_out_last && w_xfer;
endmodule
`default_nettype wire

// File: tb/tb_local_average_pad_v2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_local_average_pad_v2
// Description : Directed bench for local_average_pad_v2. Three instances
//               (replicate edges, constant edges, zero radius) share one
//               input bus; instances not under test are held in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_local_average_pad_v2;
    logic        clk = 1'b0;
    logic [8:0]  s_pixel = '0;
    logic        s_pix_valid = 1'b0;
    logic [7:0]  s_avg = '0;
    logic        s_avg_valid = 1'b0;
    logic        rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic        ready_a_fix = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
    logic        rand_mode = 1'b0, rnd_a = 1'b0;
    logic        ready_a;

    logic [16:0] a_data, b_data, c_data;
    logic        a_valid, b_valid, c_valid;
    logic        a_ovf, b_ovf, c_ovf;
    logic        a_serr, b_serr, c_serr;
    logic        a_fd, b_fd, c_fd;

    logic [16:0] qa[$], qb[$], qc[$];
    int          fd_cnt_a = 0, fd_cnt_b = 0, fd_cnt_c = 0, fd_idx_a = 0;
    logic        stall_a = 1'b0, stall_c = 1'b0;
    logic [16:0] hold_a = '0, hold_c = '0;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rnd_a <= 1'($urandom_range(0, 1));
    assign ready_a = rand_mode ? rnd_a : ready_a_fix;

    local_average_pad_v2 #(.PIX_W(8), .AVG_W(8), .RADIUS(2), .FRAME_WIDTH(8),
        .FRAME_LINES(2), .EDGE_MODE(0), .EDGE_CONST(0), .FIFO_DEPTH(8)) u_dut_a (
        .clk(clk), .reset_n(rst_a), .pixel(s_pixel), .pixel_valid(s_pix_valid),
        .local_average(s_avg), .local_average_valid(s_avg_valid), .out_ready(ready_a),
        .out_data(a_data), .out_valid(a_valid), .overflow(a_ovf),
        .sync_error(a_serr), .frame_done(a_fd));

    local_average_pad_v2 #(.PIX_W(8), .AVG_W(8), .RADIUS(2), .FRAME_WIDTH(8),
        .FRAME_LINES(2), .EDGE_MODE(1), .EDGE_CONST(128), .FIFO_DEPTH(8)) u_dut_b (
        .clk(clk), .reset_n(rst_b), .pixel(s_pixel), .pixel_valid(s_pix_valid),
        .local_average(s_avg), .local_average_valid(s_avg_valid), .out_ready(ready_b),
        .out_data(b_data), .out_valid(b_valid), .overflow(b_ovf),
        .sync_error(b_serr), .frame_done(b_fd));

    local_average_pad_v2 #(.PIX_W(8), .AVG_W(8), .RADIUS(0), .FRAME_WIDTH(8),
        .FRAME_LINES(2), .EDGE_MODE(0), .EDGE_CONST(0), .FIFO_DEPTH(8)) u_dut_c (
        .clk(clk), .reset_n(rst_c), .pixel(s_pixel), .pixel_valid(s_pix_valid),
        .local_average(s_avg), .local_average_valid(s_avg_valid), .out_ready(ready_c),
        .out_data(c_data), .out_valid(c_valid), .overflow(c_ovf),
        .sync_error(c_serr), .frame_done(c_fd));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        s_pix_valid = 1'b0;
        s_avg_valid = 1'b0;
    endtask

    // Expected beat: dut 0 = replicate edges, 1 = constant 0x80 edges, 2 = no radius.
    function automatic logic [16:0] exp_beat(input int dut, input int line, input int col);
        logic [7:0] pix, avg, base;
        pix = 8'(line * 16 + col);
        base = 8'(16 + 16 * line);
        if (dut == 0)
            avg = (col < 2) ? base : (col >= 6) ? base + 8'd3 : base + 8'(col - 2);
        else if (dut == 1)
            avg = (col < 2 || col >= 6) ? 8'h80 : base + 8'(col - 2);
        else
            avg = 8'(160 + 16 * line + col);
        return {(line == 0 && col == 0), avg, pix};
    endfunction

    // One line: pixel i on step i, average k on step k+avg_off.
    task automatic feed_line(input int line, input int n_avg, input int avg_off,
                             input logic [7:0] avg_base, input int gap, input int pause_after);
        int steps;
        steps = (n_avg + avg_off > 8) ? n_avg + avg_off : 8;
        for (int i = 0; i < steps; i++) begin
            s_pix_valid = (i < 8);
            s_pixel     = {(line == 0 && i == 0), 8'(line * 16 + i)};
            s_avg_valid = (i >= avg_off) && (i < avg_off + n_avg);
            s_avg       = avg_base + 8'(i - avg_off);
            tick;
            idle;
            repeat (gap) tick;
            if (i == pause_after) begin
                repeat (3) tick;
                chk("lead_before_avg_b", 32'(qb.size()), 32'd2);
            end
        end
    endtask

    // Output collection and hold-while-stalled checks.
    always @(negedge clk) begin
        if (a_valid && ready_a) qa.push_back(a_data);
        if (b_valid && ready_b) qb.push_back(b_data);
        if (c_valid && ready_c) qc.push_back(c_data);
        if (a_fd) begin
            fd_cnt_a++;
            fd_idx_a = qa.size();
        end
        if (b_fd) fd_cnt_b++;
        if (c_fd) fd_cnt_c++;
        if (stall_a && a_valid) chk("stall_hold_a", 32'(a_data), 32'(hold_a));
        if (stall_c && c_valid) chk("stall_hold_c", 32'(c_data), 32'(hold_c));
        stall_a = a_valid && !ready_a;
        hold_a  = a_data;
        stall_c = c_valid && !ready_c;
        hold_c  = c_data;
    end

    initial begin
        repeat (3) tick;
        chk("reset_valid_a", 32'(a_valid), 32'd0);
        chk("reset_data_a", 32'(a_data), 32'd0);
        chk("reset_ovf_a", 32'(a_ovf), 32'd0);
        chk("reset_serr_a", 32'(a_serr), 32'd0);
        chk("reset_fd_a", 32'(a_fd), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick;

        // Replicate and constant edge modes on the same two-line frame.
        feed_line(0, 4, 2, 8'h10, 0, 1);
        feed_line(1, 4, 2, 8'h20, 0, -1);
        for (int t = 0; t < 200 && (qa.size() < 16 || qb.size() < 16); t++) tick;
        chk("frame1_count_a", 32'(qa.size()), 32'd16);
        chk("frame1_count_b", 32'(qb.size()), 32'd16);
        for (int k = 0; k < 16 && k < qa.size(); k++)
            chk("frame1_beat_a", 32'(qa[k]), 32'(exp_beat(0, k / 8, k % 8)));
        for (int k = 0; k < 16 && k < qb.size(); k++)
            chk("frame1_beat_b", 32'(qb[k]), 32'(exp_beat(1, k / 8, k % 8)));
        chk("frame1_fd_cnt_a", 32'(fd_cnt_a), 32'd1);
        chk("frame1_fd_idx_a", 32'(fd_idx_a), 32'd16);
        chk("frame1_fd_cnt_b", 32'(fd_cnt_b), 32'd1);
        chk("frame1_ovf_a", 32'(a_ovf), 32'd0);

        // Random backpressure on the replicate instance.
        rst_b = 1'b0;
        rand_mode = 1'b1;
        feed_line(0, 4, 2, 8'h10, 3, -1);
        feed_line(1, 4, 2, 8'h20, 3, -1);
        for (int t = 0; t < 400 && qa.size() < 32; t++) tick;
        rand_mode = 1'b0;
        tick;
        chk("frame2_count_a", 32'(qa.size()), 32'd32);
        for (int k = 16; k < 32 && k < qa.size(); k++)
            chk("frame2_beat_a", 32'(qa[k]), 32'(exp_beat(0, (k - 16) / 8, k % 8)));
        chk("frame2_fd_cnt_a", 32'(fd_cnt_a), 32'd2);
        chk("frame2_ovf_a", 32'(a_ovf), 32'd0);

        // SOF injected at line 0 col 5.
        for (int i = 0; i < 5; i++) begin
            s_pix_valid = 1'b1;
            s_pixel     = {(i == 0), 8'(8'h40 + i)};
            s_avg_valid = (i >= 1);
            s_avg       = 8'(8'h10 + i - 1);
            tick;
            idle;
        end
        repeat (6) tick;
        chk("pre_sync_count_a", 32'(qa.size()), 32'd37);
        if (qa.size() >= 37) chk("pre_sync_beat_a", 32'(qa[36]), 32'h01244);
        chk("pre_sync_serr_a", 32'(a_serr), 32'd0);
        s_pix_valid = 1'b1;
        s_pixel     = {1'b1, 8'h55};
        tick;
        idle;
        chk("sync_error_a", 32'(a_serr), 32'd1);
        s_avg_valid = 1'b1;
        s_avg       = 8'h77;
        tick;
        idle;
        s_pix_valid = 1'b1;
        s_pixel     = {1'b0, 8'h56};
        tick;
        idle;
        for (int t = 0; t < 50 && qa.size() < 39; t++) tick;
        chk("resync_count_a", 32'(qa.size()), 32'd39);
        if (qa.size() >= 39) begin
            chk("resync_sof_beat_a", 32'(qa[37]), 32'h17755);
            chk("resync_col1_beat_a", 32'(qa[38]), 32'h07756);
        end

        // Overflow: depth 8, output blocked, nine pixels.
        rst_a = 1'b0;
        tick;
        chk("reset2_valid_a", 32'(a_valid), 32'd0);
        chk("reset2_data_a", 32'(a_data), 32'd0);
        chk("reset2_serr_a", 32'(a_serr), 32'd0);
        rst_a = 1'b1;
        ready_a_fix = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_pix_valid = 1'b1;
            s_pixel     = {(i == 0), 8'(8'h60 + i)};
            tick;
            idle;
        end
        chk("overflow_set_a", 32'(a_ovf), 32'd1);
        chk("overflow_no_beat_a", 32'(a_valid), 32'd0);
        ready_a_fix = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_avg_valid = 1'b1;
            s_avg       = 8'(8'h90 + k);
            tick;
            idle;
        end
        for (int t = 0; t < 60 && qa.size() < 47; t++) tick;
        repeat (10) tick;
        chk("overflow_count_a", 32'(qa.size()), 32'd47);
        for (int k = 0; k < 8 && 39 + k < qa.size(); k++)
            chk("overflow_pix_a", 32'(qa[39 + k][7:0]), 32'(8'h60 + k));
        chk("overflow_sticky_a", 32'(a_ovf), 32'd1);
        rst_a = 1'b0;
        tick;
        chk("overflow_clear_a", 32'(a_ovf), 32'd0);

        // Zero radius: eight averages per line, no edge beats.
        rst_c = 1'b1;
        tick;
        feed_line(0, 8, 1, 8'hA0, 0, -1);
        feed_line(1, 8, 1, 8'hB0, 0, -1);
        for (int t = 0; t < 200 && qc.size() < 16; t++) tick;
        chk("r0_count_c", 32'(qc.size()), 32'd16);
        for (int k = 0; k < 16 && k < qc.size(); k++)
            chk("r0_beat_c", 32'(qc[k]), 32'(exp_beat(2, k / 8, k % 8)));
        chk("r0_fd_cnt_c", 32'(fd_cnt_c), 32'd1);

        // Asynchronous reset in the middle of a stalled line.
        ready_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_pix_valid = 1'b1;
            s_pixel     = {(i == 0), 8'(i)};
            s_avg_valid = (i >= 1);
            s_avg       = 8'(8'hA0 + i - 1);
            tick;
            idle;
        end
        repeat (2) tick;
        chk("midline_valid_c", 32'(c_valid), 32'd1);
        rst_c = 1'b0;
        #1;
        chk("async_reset_valid_c", 32'(c_valid), 32'd0);
        chk("async_reset_data_c", 32'(c_data), 32'd0);
        tick;
        rst_c = 1'b1;
        ready_c = 1'b1;
        tick;
        feed_line(0, 8, 1, 8'hA0, 0, -1);
        feed_line(1, 8, 1, 8'hB0, 0, -1);
        for (int t = 0; t < 200 && qc.size() < 32; t++) tick;
        chk("after_reset_count_c", 32'(qc.size()), 32'd32);
        for (int k = 16; k < 32 && k < qc.size(); k++)
            chk("after_reset_beat_c", 32'(qc[k]), 32'(exp_beat(2, (k - 16) / 8, k % 8)));
        chk("after_reset_fd_cnt_c", 32'(fd_cnt_c), 32'd2);
        chk("ovf_c", 32'(c_ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
